// File: rtl/bitcell_array_ctrl.sv
// Request-driven read/write sequencer for the NAND-latch bitcell array.
// Define BITCELL_CTRL_READBACK_EN to add a verify read (VSETUP/VSTROBE/VHOLD) after every write.
module bitcell_array_ctrl #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 8,
   parameter int WR_CYCLES = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_req_valid,
   output logic                   o_req_ready,
   input  logic                   i_req_we,
   input  logic [ADDR_W-1:0]      i_req_addr,
   input  logic [DATA_W-1:0]      i_req_wdata,
   output logic                   o_rsp_valid,
   input  logic                   i_rsp_ready,
   output logic [DATA_W-1:0]      o_rsp_rdata,
   output logic                   o_rsp_err,
   output logic [(2**ADDR_W)-1:0] o_cell_sel,
   output logic                   o_cell_rw,
   output logic [DATA_W-1:0]      o_cell_in,
   input  logic [DATA_W-1:0]      i_cell_out
);
   localparam int ROWS = 2**ADDR_W;

`ifdef BITCELL_CTRL_READBACK_EN
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      STROBE  = 3'd2,
      HOLD    = 3'd3,
      RESP    = 3'd4,
      VSETUP  = 3'd5,
      VSTROBE = 3'd6,
      VHOLD   = 3'd7
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      STROBE  = 3'd2,
      HOLD    = 3'd3,
      RESP    = 3'd4
   } state_t;
`endif

   state_t              r_state;
   state_t              w_nextState;
   logic [1:0]          r_rstSync;
   logic                w_rstN;
   logic                w_accept;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [3:0]          r_cnt;
   logic [ROWS-1:0]     w_rowHot;
   logic [ROWS-1:0]     w_selNext;
   logic                w_rwNext;
   logic [DATA_W-1:0]   w_inNext;
   logic                w_validNext;
   logic [ROWS-1:0]     r_cellSel;
   logic                r_cellRw;
   logic [DATA_W-1:0]   r_cellIn;
   logic                r_rspValid;
   logic [DATA_W-1:0]   r_rspRdata;

   // Reset asserts asynchronously but releases only on a clock edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rstSync <= 2'b00;
      end else begin
         r_rstSync <= {r_rstSync[0], 1'b1};
      end
   end
   assign w_rstN = r_rstSync[1];

   assign o_req_ready = (r_state == IDLE) && w_rstN;
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_rowHot    = {{(ROWS-1){1'b0}}, 1'b1} << r_addr;

   always_ff @(posedge i_clk or negedge w_rstN) begin
      if (!w_rstN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = SETUP;
         SETUP:   w_nextState = STROBE;
         STROBE:  if (r_cnt == 4'd0) w_nextState = HOLD;
`ifdef BITCELL_CTRL_READBACK_EN
         HOLD:    w_nextState = r_we ? VSETUP : RESP;
         VSETUP:  w_nextState = VSTROBE;
         VSTROBE: w_nextState = VHOLD;
         VHOLD:   w_nextState = RESP;
`else
         HOLD:    w_nextState = RESP;
`endif
         RESP:    if (i_rsp_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Cell drives are computed from the upcoming state and registered, so
   // rw/in only ever move on edges where sel is low before and after.
   always_comb begin
      w_selNext   = '0;
      w_rwNext    = r_cellRw;
      w_inNext    = r_cellIn;
      w_validNext = (w_nextState == RESP);
      case (w_nextState)
         SETUP: begin
            w_rwNext = i_req_we;
            w_inNext = i_req_we ? i_req_wdata : '0;
         end
         STROBE:  w_selNext = w_rowHot;
`ifdef BITCELL_CTRL_READBACK_EN
         VSETUP:  w_rwNext  = 1'b0;
         VSTROBE: w_selNext = w_rowHot;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge w_rstN) begin
      if (!w_rstN) begin
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_cnt      <= 4'd0;
         r_cellSel  <= '0;
         r_cellRw   <= 1'b0;
         r_cellIn   <= '0;
         r_rspValid <= 1'b0;
         r_rspRdata <= '0;
      end else begin
         if (w_accept) begin
            r_we    <= i_req_we;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
         end
         if (r_state == SETUP) begin
            r_cnt <= r_we ? 4'(WR_CYCLES - 1) : 4'd0;
         end else if ((r_state == STROBE) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if ((r_state == STROBE) && (r_cnt == 4'd0)) begin
            r_rspRdata <= r_we ? r_wdata : i_cell_out;
         end
`ifdef BITCELL_CTRL_READBACK_EN
         if (r_state == VSTROBE) begin
            r_rspRdata <= i_cell_out;
         end
`endif
         r_cellSel  <= w_selNext;
         r_cellRw   <= w_rwNext;
         r_cellIn   <= w_inNext;
         r_rspValid <= w_validNext;
      end
   end

`ifdef BITCELL_CTRL_READBACK_EN
   logic r_rspErr;

   // The error flag belongs to the current request, so clear it on accept.
   always_ff @(posedge i_clk or negedge w_rstN) begin
      if (!w_rstN) begin
         r_rspErr <= 1'b0;
      end else if (w_accept) begin
         r_rspErr <= 1'b0;
      end else if (r_state == VSTROBE) begin
         r_rspErr <= (i_cell_out != r_wdata);
      end
   end
   assign o_rsp_err = r_rspErr;
`else
   assign o_rsp_err = 1'b0;
`endif

   assign o_cell_sel  = r_cellSel;
   assign o_cell_rw   = r_cellRw;
   assign o_cell_in   = r_cellIn;
   assign o_rsp_valid = r_rspValid;
   assign o_rsp_rdata = r_rspRdata;

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Scoreboard bench for bitcell_array_ctrl with a behavioural bitcell array model.
// Honours BITCELL_CTRL_READBACK_EN (row 7 bit 0 is then stuck at 0 in the array model).
`timescale 1ns/1ps
module tb_bitcell_array_ctrl;
   localparam int ADDR_W    = 4;
   localparam int DATA_W    = 8;
   localparam int WR_CYCLES = 2;
   localparam int ROWS      = 16;
`ifdef BITCELL_CTRL_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif
   // Latency = rising edges counted from the accept edge (inclusive) until rsp_valid is seen.
   localparam int RD_LAT = 4;
   localparam int WR_LAT = 3 + WR_CYCLES + (RB ? 3 : 0);

   typedef struct {
      logic [7:0] rdata;
      logic       err;
   } exp_t;

   logic              clock;
   logic              resetN;
   logic              reqValid;
   logic              reqReady;
   logic              reqWe;
   logic [3:0]        reqAddr;
   logic [7:0]        reqWdata;
   logic              rspValid;
   logic              rspReady;
   logic [7:0]        rspRdata;
   logic              rspErr;
   logic [ROWS-1:0]   cellSel;
   logic              cellRw;
   logic [7:0]        cellIn;
   logic [7:0]        cellOut;

   logic [7:0]        cellMem [ROWS];
   logic [7:0]        shadow  [ROWS];
   exp_t              expQ [$];

   int                vecCount;
   int                missCount;
   int                selCycles;
   int                wrSelCycles;
   logic [ROWS-1:0]   lastSel;
   logic [ROWS-1:0]   prevSel;
   logic              prevRw;
   logic [7:0]        prevIn;

   bitcell_array_ctrl #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .WR_CYCLES (WR_CYCLES)
   ) dut (
      .i_clk       (clock),
      .i_rst_n     (resetN),
      .i_req_valid (reqValid),
      .o_req_ready (reqReady),
      .i_req_we    (reqWe),
      .i_req_addr  (reqAddr),
      .i_req_wdata (reqWdata),
      .o_rsp_valid (rspValid),
      .i_rsp_ready (rspReady),
      .o_rsp_rdata (rspRdata),
      .o_rsp_err   (rspErr),
      .o_cell_sel  (cellSel),
      .o_cell_rw   (cellRw),
      .o_cell_in   (cellIn),
      .i_cell_out  (cellOut)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [7:0] stuckMask(input int row, input logic [7:0] d);
      return (RB && (row == 7)) ? (d & 8'hFE) : d;
   endfunction

   // Bitcell array model: selected rows latch 'in' while r_w is high.
   always @(posedge clock) begin
      for (int r = 0; r < ROWS; r++) begin
         if (cellSel[r] && cellRw) cellMem[r] <= stuckMask(r, cellIn);
      end
   end

   always_comb begin
      cellOut = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (cellSel[r]) cellOut = cellOut | cellMem[r];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: pops one expectation per response handshake.
   always @(negedge clock) begin
      exp_t e;
      if (resetN && rspValid && rspReady) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_rsp", 32'(expQ.size()), 32'd1);
         end else begin
            e = expQ.pop_front();
            checkOutput("rsp_rdata", 32'(rspRdata), 32'(e.rdata));
            checkOutput("rsp_err", 32'(rspErr), 32'(e.err));
         end
      end
   end

   // Glitch checker and strobe bookkeeping on the cell interface.
   always @(negedge clock) begin
      if (resetN) begin
         if ((cellRw !== prevRw) || (cellIn !== prevIn))
            checkOutput("rw_in_change_under_sel", 32'(prevSel | cellSel), 32'd0);
         if (cellSel != '0) begin
            checkOutput("sel_onehot", 32'($onehot(cellSel)), 32'd1);
            selCycles++;
            lastSel = cellSel;
            if (cellRw) wrSelCycles++;
         end
      end
      prevSel = cellSel;
      prevRw  = cellRw;
      prevIn  = cellIn;
   end

   task automatic waitReady();
      int guard;
      guard = 0;
      while (!reqReady && (guard < 50)) begin
         @(posedge clock); #1;
         guard++;
      end
      checkOutput("req_ready_wait", 32'(reqReady), 32'd1);
   endtask

   task automatic pushExpect(input logic we, input logic [3:0] addr, input logic [7:0] data);
      exp_t        e;
      logic [7:0]  stored;
      if (we) begin
         stored       = stuckMask(int'(addr), data);
         shadow[addr] = stored;
         e.rdata      = RB ? stored : data;
         e.err        = RB && (stored != data);
      end else begin
         e.rdata = shadow[addr];
         e.err   = 1'b0;
      end
      expQ.push_back(e);
      selCycles   = 0;
      wrSelCycles = 0;
      lastSel     = '0;
   endtask

   task automatic finishTxn(input logic we, input logic [3:0] addr);
      int lat;
      int guard;
      lat = 1;
      while (!rspValid && (lat < 40)) begin
         @(posedge clock); #1;
         lat++;
      end
      checkOutput("latency", 32'(lat), 32'(we ? WR_LAT : RD_LAT));
      guard = 0;
      while (rspValid && (guard < 20)) begin
         @(posedge clock); #1;
         guard++;
      end
      checkOutput("rsp_handshake", 32'(rspValid), 32'd0);
      checkOutput("sel_cycles", 32'(selCycles), 32'(we ? (WR_CYCLES + (RB ? 1 : 0)) : 1));
      checkOutput("write_sel_cycles", 32'(wrSelCycles), 32'(we ? WR_CYCLES : 0));
      checkOutput("sel_row", 32'(lastSel), 32'(1) << addr);
   endtask

   task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [7:0] data);
      waitReady();
      reqValid = 1'b1;
      reqWe    = we;
      reqAddr  = addr;
      reqWdata = data;
      @(posedge clock); #1;
      reqValid = 1'b0;
      pushExpect(we, addr, data);
      finishTxn(we, addr);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int guard;
      vecCount    = 0;
      missCount   = 0;
      selCycles   = 0;
      wrSelCycles = 0;
      lastSel     = '0;
      prevSel     = '0;
      prevRw      = 1'b0;
      prevIn      = '0;
      reqValid    = 1'b0;
      reqWe       = 1'b0;
      reqAddr     = '0;
      reqWdata    = '0;
      rspReady    = 1'b1;
      for (int r = 0; r < ROWS; r++) begin
         cellMem[r] = '0;
         shadow[r]  = '0;
      end

      // Reset state.
      resetN = 1'b1;
      #2 resetN = 1'b0;
      #1;
      checkOutput("reset_req_ready", 32'(reqReady), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("reset_rsp_rdata", 32'(rspRdata), 32'd0);
      checkOutput("reset_rsp_err", 32'(rspErr), 32'd0);
      checkOutput("reset_cell_sel", 32'(cellSel), 32'd0);
      checkOutput("reset_cell_rw", 32'(cellRw), 32'd0);
      checkOutput("reset_cell_in", 32'(cellIn), 32'd0);
      repeat (2) @(negedge clock);
      resetN = 1'b1;
      @(posedge clock); #1;
      waitReady();

      $display("[TB] directed read/write");
      applyStimulus(1'b0, 4'd3, 8'h00);
      applyStimulus(1'b1, 4'd5, 8'hA5);
      applyStimulus(1'b0, 4'd5, 8'h00);
      applyStimulus(1'b0, 4'd4, 8'h00);
      applyStimulus(1'b0, 4'd6, 8'h00);

      $display("[TB] response backpressure");
      waitReady();
      rspReady = 1'b0;
      reqValid = 1'b1;
      reqWe    = 1'b0;
      reqAddr  = 4'd5;
      @(posedge clock); #1;
      pushExpect(1'b0, 4'd5, 8'h00);
      reqAddr  = 4'd3;
      guard = 0;
      while (!rspValid && (guard < 40)) begin
         @(posedge clock); #1;
         guard++;
      end
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_rsp_valid", 32'(rspValid), 32'd1);
         checkOutput("bp_rsp_rdata", 32'(rspRdata), 32'hA5);
         checkOutput("bp_req_ready", 32'(reqReady), 32'd0);
         @(posedge clock); #1;
      end
      rspReady = 1'b1;
      @(posedge clock); #1;
      checkOutput("bp_after_hs_valid", 32'(rspValid), 32'd0);
      checkOutput("bp_after_hs_ready", 32'(reqReady), 32'd1);
      @(posedge clock); #1;
      reqValid = 1'b0;
      checkOutput("bp_pending_accepted", 32'(reqReady), 32'd0);
      pushExpect(1'b0, 4'd3, 8'h00);
      finishTxn(1'b0, 4'd3);

      $display("[TB] reset during write strobe");
      waitReady();
      reqValid = 1'b1;
      reqWe    = 1'b1;
      reqAddr  = 4'd2;
      reqWdata = 8'h5A;
      @(posedge clock); #1;
      reqValid = 1'b0;
      @(posedge clock); #1;
      checkOutput("strobe_sel_before_reset", 32'(cellSel), 32'h0004);
      #2 resetN = 1'b0;
      #1;
      checkOutput("mid_reset_cell_sel", 32'(cellSel), 32'd0);
      checkOutput("mid_reset_rsp_valid", 32'(rspValid), 32'd0);
      repeat (2) @(negedge clock);
      resetN = 1'b1;
      @(posedge clock); #1;
      waitReady();
      checkOutput("post_reset_rsp_valid", 32'(rspValid), 32'd0);
      applyStimulus(1'b1, 4'd2, 8'h3C);
      applyStimulus(1'b0, 4'd2, 8'h00);

      $display("[TB] row 7 writes");
      applyStimulus(1'b1, 4'd7, 8'h01);
      applyStimulus(1'b1, 4'd7, 8'h02);
      applyStimulus(1'b0, 4'd7, 8'h00);

      $display("[TB] random request run");
      for (int n = 0; n < 200; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
      end

      guard = 0;
      while ((expQ.size() != 0) && (guard < 50)) begin
         @(posedge clock); #1;
         guard++;
      end
      checkOutput("queue_drain", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
